// File: rtl/nibble_word_bank_pkg.sv
// Shared types and constants for the nibble word bank: FSM state encoding
// and the active-low seven-segment pattern table.
package nwb_pkg;

    typedef enum logic [1:0] {
        EDIT   = 2'd0,
        COMMIT = 2'd1,
        VIEW   = 2'd2
    } state_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}; entry 0 is last.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] hex2seg(input logic [3:0] v);
        return SEG_LUT[v];
    endfunction

endpackage

// File: rtl/nibble_word_bank_if.sv
// Switch/button/display bundle between the board-side driver and the bank.
interface nwb_if #(
    parameter int NUM_WORDS = 4,
    parameter int NIBBLES   = 4
);
    localparam int NSW = (NIBBLES   > 1) ? $clog2(NIBBLES)   : 1;
    localparam int WSW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    logic [3:0]           din;
    logic [NSW-1:0]       nib_sel;
    logic [WSW-1:0]       word_sel;
    logic                 load_btn;
    logic                 commit_btn;
    logic                 view;
    logic [6:0]           seg;
    logic                 dp;
    logic [NIBBLES-1:0]   an;
    logic [4*NIBBLES-1:0] led;

    modport master (
        output din, nib_sel, word_sel, load_btn, commit_btn, view,
        input  seg, dp, an, led
    );

    modport slave (
        input  din, nib_sel, word_sel, load_btn, commit_btn, view,
        output seg, dp, an, led
    );
endinterface

// File: rtl/nibble_word_bank_seg7_scan.sv
// Multiplexed seven-segment scanner: holds each digit for REFRESH_DIV
// cycles, rotating through NIBBLES digits, with registered an/seg/dp.
module seg7_scan
    import nwb_pkg::*;
#(
    parameter int  NIBBLES     = 4,
    parameter int  REFRESH_DIV = 100000,
    localparam int DW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1,
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NIBBLES-1:0][3:0] value,
    input  logic                    dp_en,
    input  logic [DW-1:0]           dp_idx,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NIBBLES-1:0]      an
);

    logic [CW-1:0] cnt;
    logic [DW-1:0] digit;

    // Refresh divider; the digit index steps once per wrap.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt   <= '0;
            digit <= '0;
        end else if (cnt == CW'(REFRESH_DIV - 1)) begin
            cnt   <= '0;
            digit <= (digit == DW'(NIBBLES - 1)) ? '0 : digit + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Registered drive so the pins are glitch-free and blank during reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            an  <= '1;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= ~(NIBBLES'(1) << digit);
            seg <= hex2seg(value[digit]);
            dp  <= ~(dp_en && (dp_idx == digit));
        end
    end

endmodule

// File: rtl/nibble_word_bank.sv
// Nibble-entry word bank: buttons load hex digits into a staging word,
// commit it into one of NUM_WORDS bank entries, and a VIEW mode scans a
// stored word onto the display.
module nibble_word_bank
    import nwb_pkg::*;
#(
    parameter int NUM_WORDS   = 4,
    parameter int NIBBLES     = 4,
    parameter int REFRESH_DIV = 100000
) (
    input logic   clk,
    input logic   reset,
    nwb_if.slave  bus
);

    logic [1:0] sync1, sync2, prev;   // bit 0 = load, bit 1 = commit
    logic [1:0] pulse;
    logic       nib_ok, word_ok;
    state_t     state;

    logic [NIBBLES-1:0][3:0]                 staging;
    logic [NUM_WORDS-1:0][NIBBLES-1:0][3:0]  bank;
    logic [NIBBLES-1:0][3:0]                 view_word, disp;
    logic [NIBBLES-1:0][3:0]                 led_r;

    assign pulse   = sync2 & ~prev;
    assign nib_ok  = 32'(bus.nib_sel)  < NIBBLES;
    assign word_ok = 32'(bus.word_sel) < NUM_WORDS;

    // Two-flop synchronizer plus edge register for both buttons.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= {bus.commit_btn, bus.load_btn};
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Mode FSM with staging and bank storage; a pulse arriving in VIEW is dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= EDIT;
            staging <= '0;
            bank    <= '0;
        end else begin
            case (state)
                EDIT: begin
                    if (pulse[0] && nib_ok)
                        staging[bus.nib_sel] <= bus.din;
                    if (bus.view)
                        state <= VIEW;
                    else if (pulse[1])
                        state <= COMMIT;
                end
                COMMIT: begin
                    // Writing here picks up a load that landed alongside the commit.
                    if (word_ok)
                        bank[bus.word_sel] <= staging;
                    state <= bus.view ? VIEW : EDIT;
                end
                VIEW: begin
                    if (!bus.view)
                        state <= EDIT;
                end
                default: state <= EDIT;
            endcase
        end
    end

    assign view_word = word_ok ? bank[bus.word_sel] : '0;
    assign disp      = (state == VIEW) ? view_word : staging;

    // LED mirror of the selected bank word, one cycle behind.
    always_ff @(posedge clk) begin
        if (!reset)
            led_r <= '0;
        else
            led_r <= view_word;
    end

    assign bus.led = led_r;

    seg7_scan #(
        .NIBBLES     (NIBBLES),
        .REFRESH_DIV (REFRESH_DIV)
    ) u_scan (
        .clk    (clk),
        .reset  (reset),
        .value  (disp),
        .dp_en  (state == EDIT),
        .dp_idx (bus.nib_sel),
        .seg    (bus.seg),
        .dp     (bus.dp),
        .an     (bus.an)
    );

endmodule

// File: tb/tb_nibble_word_bank.sv
// Directed bench for nibble_word_bank with a short refresh period.
module tb_nibble_word_bank;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    nwb_if #(.NUM_WORDS(4), .NIBBLES(4)) bus ();

    nibble_word_bank #(
        .NUM_WORDS   (4),
        .NIBBLES     (4),
        .REFRESH_DIV (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input bit ld, input bit cm);
        bus.load_btn   = ld;
        bus.commit_btn = cm;
        tick();
        bus.load_btn   = 1'b0;
        bus.commit_btn = 1'b0;
        tick(6);
    endtask

    task automatic wait_an(input logic [3:0] exp, input string tag);
        int k = 0;
        while (bus.an !== exp && k < 40) begin
            tick();
            k++;
        end
        if (k >= 40) chk(tag, 16'(bus.an), 16'(exp));
    endtask

    task automatic wait_an_not(input logic [3:0] v, input string tag);
        int k = 0;
        while (bus.an === v && k < 40) begin
            tick();
            k++;
        end
        if (k >= 40) chk(tag, 16'(bus.an), 16'(~v));
    endtask

    initial begin
        reset          = 1'b0;
        bus.din        = '0;
        bus.nib_sel    = '0;
        bus.word_sel   = '0;
        bus.load_btn   = 1'b0;
        bus.commit_btn = 1'b0;
        bus.view       = 1'b0;

        // Reset values
        tick(3);
        chk("rst_an",  16'(bus.an),  16'hF);
        chk("rst_seg", 16'(bus.seg), 16'h7F);
        chk("rst_dp",  16'(bus.dp),  16'h1);
        chk("rst_led", bus.led,      16'h0);
        reset = 1'b1;
        tick();
        chk("rel_an",  16'(bus.an),  16'hE);
        chk("rel_seg", 16'(bus.seg), 16'h40);
        chk("rel_dp",  16'(bus.dp),  16'h0);

        // Load 1,2,3,4 into digits 0..3 and commit to word 2 with exact timing
        for (int i = 0; i < 4; i++) begin
            bus.din     = 4'(i + 1);
            bus.nib_sel = 2'(i);
            press(1'b1, 1'b0);
        end
        bus.word_sel   = 2'd2;
        bus.commit_btn = 1'b1;
        tick();                       // level first sampled
        bus.commit_btn = 1'b0;
        tick(3);                      // pulse, COMMIT, bank write
        chk("commit_led_early", bus.led, 16'h0000);
        tick();
        chk("commit_led", bus.led, 16'h4321);

        // Held load button: one write only, later din changes ignored
        bus.din      = 4'hA;
        bus.nib_sel  = 2'd1;
        bus.load_btn = 1'b1;
        tick(10);
        bus.din = 4'h5;
        tick(40);
        bus.load_btn = 1'b0;
        tick(5);
        wait_an(4'hD, "hold_an_timeout");
        chk("hold_seg", 16'(bus.seg), 16'h08);
        bus.word_sel = 2'd1;
        press(1'b0, 1'b1);
        chk("hold_led", bus.led, 16'h43A1);

        // VIEW mode: pulses dropped, word 2 scanned on the display
        bus.view     = 1'b1;
        bus.word_sel = 2'd2;
        tick(2);
        bus.din     = 4'hF;
        bus.nib_sel = 2'd0;
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        chk("view_led", bus.led, 16'h4321);
        wait_an_not(4'hE, "scan_leave_timeout");
        wait_an(4'hE, "scan_enter_timeout");
        chk("scan0_seg", 16'(bus.seg), 16'h79);
        chk("scan0_dp",  16'(bus.dp),  16'h1);
        tick(4);
        chk("scan1_an",  16'(bus.an),  16'hD);
        chk("scan1_seg", 16'(bus.seg), 16'h24);
        tick(4);
        chk("scan2_an",  16'(bus.an),  16'hB);
        chk("scan2_seg", 16'(bus.seg), 16'h30);
        tick(4);
        chk("scan3_an",  16'(bus.an),  16'h7);
        chk("scan3_seg", 16'(bus.seg), 16'h19);
        tick(4);
        chk("scan_wrap_an", 16'(bus.an), 16'hE);

        // Back to EDIT: staging digit 0 still 1, dp marks nib_sel 0
        bus.view = 1'b0;
        tick(2);
        wait_an_not(4'hE, "edit_leave_timeout");
        wait_an(4'hE, "edit_enter_timeout");
        chk("edit_seg", 16'(bus.seg), 16'h79);
        chk("edit_dp",  16'(bus.dp),  16'h0);
        bus.word_sel = 2'd3;
        tick(2);
        chk("view_commit_dropped", bus.led, 16'h0000);

        // Same-cycle load and commit into word 0
        bus.din     = 4'h2;
        bus.nib_sel = 2'd1;
        press(1'b1, 1'b0);
        bus.word_sel = 2'd0;
        bus.din      = 4'h9;
        bus.nib_sel  = 2'd0;
        press(1'b1, 1'b1);
        chk("merge_led", bus.led, 16'h4329);

        // Reset during COMMIT aborts the write to word 3
        bus.word_sel   = 2'd3;
        bus.commit_btn = 1'b1;
        tick();
        bus.commit_btn = 1'b0;
        tick(2);                      // now in COMMIT
        reset = 1'b0;
        tick(2);
        chk("abort_an",  16'(bus.an),  16'hF);
        chk("abort_seg", 16'(bus.seg), 16'h7F);
        chk("abort_dp",  16'(bus.dp),  16'h1);
        chk("abort_led", bus.led,      16'h0);
        reset = 1'b1;
        tick();
        chk("abort_rel_an", 16'(bus.an), 16'hE);
        for (int w = 0; w < 4; w++) begin
            bus.word_sel = 2'(w);
            tick(2);
            chk($sformatf("abort_bank%0d", w), bus.led, 16'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
